// File: rtl/hpdc_l15_store_buf.sv
// hpdc_l15_store_buf
//   Write-through store buffer between the HPDcache store path and the
//   OpenPiton L1.5 request port. Stores are queued in a circular buffer and
//   issued in order, with data and byte enables byte-swapped for the
//   big-endian NoC. In-flight stores (issued, not yet completed) are bounded
//   by an outstanding counter.
//
//   Optional feature macro: HPDC_L15_STORE_BUF_MERGE_EN
//     defined   - a cacheable store to the same doubleword as the tail entry
//                 is merged into it (bytewise overwrite, be OR-ed), unless the
//                 tail is the head currently being presented to the L1.5.
//     undefined - every accepted store takes its own entry.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   st_valid_i/st_ready_o         store request handshake
//   st_addr_i/st_data_i/st_be_i   store doubleword address, LE data, byte enables
//   st_nc_i                       non-cacheable store (never merged)
//   flush_i                       drain request (level)
//   l15_req_*                     request to L1.5 (val/ack handshake), swapped lanes
//   l15_st_ack_i                  store completion, one per issued store
//   empty_o                       no entries and nothing outstanding
//   outst_cnt_o                   current outstanding count
module hpdc_l15_store_buf #(
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 7,
    parameter int ADDR_W          = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [63:0]       st_data_i,
    input  logic [7:0]        st_be_i,
    input  logic              st_nc_i,
    input  logic              flush_i,
    output logic              l15_req_val_o,
    input  logic              l15_req_ack_i,
    output logic [ADDR_W-1:0] l15_req_addr_o,
    output logic [63:0]       l15_req_data_o,
    output logic [7:0]        l15_req_be_o,
    output logic              l15_req_nc_o,
    input  logic              l15_st_ack_i,
    output logic              empty_o,
    output logic [3:0]        outst_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_W - 3;

`ifdef HPDC_L15_STORE_BUF_MERGE_EN
    localparam bit MergeEn = 1'b1;
`else
    localparam bit MergeEn = 1'b0;
`endif

    typedef enum logic {RUN, DRAIN} state_e;

    // Entry payload (not reset: only the valid bits and pointers matter)
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [7:0]       be_q   [DEPTH];
    logic [DEPTH-1:0] nc_q;

    // Control state
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       outst_q, outst_d;
    state_e           state_q;

    logic [PTR_W-1:0] tail_idx;
    logic             merge_hit, st_acc, push, pop, ack_ok;
    logic [63:0]      merged_data;
    logic             addr_lo_unused;

    assign addr_lo_unused = ^st_addr_i[2:0];
    assign tail_idx       = wr_ptr_q - PTR_W'(1);

    assign l15_req_val_o = rst_ni && (count_q != '0) && (outst_q < 4'(MAX_OUTSTANDING));

    // The presented head must stay stable until acked, so a tail that is
    // also the presented head is not a merge target.
    assign merge_hit = MergeEn && st_valid_i && (count_q != '0) && vld_q[tail_idx]
                     && (tag_q[tail_idx] == st_addr_i[ADDR_W-1:3])
                     && !st_nc_i && !nc_q[tail_idx]
                     && !((tail_idx == rd_ptr_q) && l15_req_val_o);

    assign st_ready_o = rst_ni && (state_q == RUN)
                      && ((count_q < CNT_W'(DEPTH)) || merge_hit);
    assign st_acc     = st_valid_i && st_ready_o;
    assign push       = st_acc && !merge_hit;
    assign pop        = l15_req_val_o && l15_req_ack_i;
    // Completion with nothing outstanding is dropped
    assign ack_ok     = l15_st_ack_i && (outst_q != '0);

    assign empty_o        = (count_q == '0) && (outst_q == '0);
    assign outst_cnt_o    = outst_q;
    assign l15_req_addr_o = {tag_q[rd_ptr_q], 3'b000};
    assign l15_req_nc_o   = nc_q[rd_ptr_q];

    always_comb begin
        l15_req_data_o = '0;
        l15_req_be_o   = '0;
        merged_data    = data_q[tail_idx];
        for (int i = 0; i < 8; i++) begin
            // NoC is big-endian: lane i of the request is entry lane 7-i
            l15_req_data_o[8*i +: 8] = data_q[rd_ptr_q][8*(7-i) +: 8];
            l15_req_be_o[i]          = be_q[rd_ptr_q][7-i];
            if (st_be_i[i]) begin
                merged_data[8*i +: 8] = st_data_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        count_d  = count_q;
        outst_d  = outst_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case ({pop, ack_ok})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_q[wr_ptr_q]  <= st_addr_i[ADDR_W-1:3];
            data_q[wr_ptr_q] <= st_data_i;
            be_q[wr_ptr_q]   <= st_be_i;
            nc_q[wr_ptr_q]   <= st_nc_i;
        end else if (st_acc) begin
            data_q[tail_idx] <= merged_data;
            be_q[tail_idx]   <= be_q[tail_idx] | st_be_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            outst_q  <= '0;
            state_q  <= RUN;
        end else begin
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
            end
            if (push) begin
                vld_q[wr_ptr_q] <= 1'b1;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            case (state_q)
                RUN: begin
                    if (flush_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((count_q == '0) && (outst_q == '0) && !flush_i) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    a_outst_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outst_q <= 4'(MAX_OUTSTANDING));
    a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CNT_W'(DEPTH));
    a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (l15_req_val_o && !l15_req_ack_i) |=> (l15_req_val_o
            && $stable(l15_req_addr_o) && $stable(l15_req_data_o)
            && $stable(l15_req_be_o) && $stable(l15_req_nc_o)));
    c_stray_st_ack: cover property (@(posedge clk_i)
        rst_ni && l15_st_ack_i && (outst_q == '0));

endmodule

// File: tb/tb_hpdc_l15_store_buf.sv
module tb_hpdc_l15_store_buf;
    localparam int DEPTH = 8;
    localparam int MAXO  = 7;
`ifdef HPDC_L15_STORE_BUF_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        st_valid = 1'b0;
    logic [63:0] st_addr = '0;
    logic [63:0] st_data = '0;
    logic [7:0]  st_be = '0;
    logic        st_nc = 1'b0;
    logic        flush = 1'b0;
    logic        req_ack = 1'b0;
    logic        st_ack = 1'b0;
    logic        st_ready_o, l15_req_val_o, l15_req_nc_o, empty_o;
    logic [63:0] l15_req_addr_o, l15_req_data_o;
    logic [7:0]  l15_req_be_o;
    logic [3:0]  outst_cnt_o;

    int checks = 0;
    int failures = 0;

    hpdc_l15_store_buf dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .st_valid_i(st_valid), .st_ready_o(st_ready_o),
        .st_addr_i(st_addr), .st_data_i(st_data), .st_be_i(st_be), .st_nc_i(st_nc),
        .flush_i(flush),
        .l15_req_val_o(l15_req_val_o), .l15_req_ack_i(req_ack),
        .l15_req_addr_o(l15_req_addr_o), .l15_req_data_o(l15_req_data_o),
        .l15_req_be_o(l15_req_be_o), .l15_req_nc_o(l15_req_nc_o),
        .l15_st_ack_i(st_ack), .empty_o(empty_o), .outst_cnt_o(outst_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: an in-order queue of pending stores plus counters
    typedef struct {
        logic [60:0] tag;
        logic [63:0] data;
        logic [7:0]  be;
        logic        nc;
    } ent_t;
    ent_t mq[$];
    int   m_outst = 0;
    bit   m_drain = 1'b0;

    function automatic logic [63:0] swap8(input logic [63:0] x);
        return {<<8{x}};
    endfunction

    function automatic logic [7:0] swapbe(input logic [7:0] x);
        return {<<{x}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        st_valid = 1'b0;
        flush    = 1'b0;
        req_ack  = 1'b0;
        st_ack   = 1'b0;
        st_nc    = 1'b0;
    endtask

    // One clock: drive, compare with model at negedge, advance model at posedge
    task automatic cyc(input logic sv, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] be, input logic nc, input logic fl,
                       input logic ack, input logic sack);
        int   n, old_outst;
        bit   e_val, e_merge, e_ready, old_drain;
        ent_t t;
        st_valid = sv; st_addr = a; st_data = d; st_be = be; st_nc = nc;
        flush = fl; req_ack = ack; st_ack = sack;
        @(negedge clk);
        n = mq.size();
        e_val = (n > 0) && (m_outst < MAXO);
        e_merge = 1'b0;
        if (MERGE && sv && n > 0 && !nc)
            e_merge = !mq[n-1].nc && (mq[n-1].tag == a[63:3]) && !(n == 1 && e_val);
        e_ready = !m_drain && ((n < DEPTH) || e_merge);
        chk("st_ready", 64'(st_ready_o), 64'(e_ready));
        chk("req_val", 64'(l15_req_val_o), 64'(e_val));
        chk("empty", 64'(empty_o), 64'(n == 0 && m_outst == 0));
        chk("outst", 64'(outst_cnt_o), 64'(m_outst));
        if (e_val) begin
            chk("req_addr", l15_req_addr_o, {mq[0].tag, 3'b000});
            chk("req_data", l15_req_data_o, swap8(mq[0].data));
            chk("req_be", 64'(l15_req_be_o), 64'(swapbe(mq[0].be)));
            chk("req_nc", 64'(l15_req_nc_o), 64'(mq[0].nc));
        end
        @(posedge clk);
        old_outst = m_outst;
        old_drain = m_drain;
        if (sv && e_ready) begin
            if (e_merge) begin
                t = mq[n-1];
                for (int i = 0; i < 8; i++)
                    if (be[i]) t.data[8*i +: 8] = d[8*i +: 8];
                t.be = t.be | be;
                mq[n-1] = t;
            end else begin
                t.tag = a[63:3]; t.data = d; t.be = be; t.nc = nc;
                mq.push_back(t);
            end
        end
        if (!old_drain && fl) m_drain = 1'b1;
        else if (old_drain && n == 0 && old_outst == 0 && !fl) m_drain = 1'b0;
        if (e_val && ack) begin
            void'(mq.pop_front());
            m_outst++;
        end
        if (sack && old_outst > 0) m_outst--;
        #1;
        set_idle();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        st_valid = 1'b1;
        @(negedge clk);
        chk("rst_ready_during", 64'(st_ready_o), 64'd0);
        chk("rst_val_during", 64'(l15_req_val_o), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        set_idle();
        mq.delete();
        m_outst = 0;
        m_drain = 1'b0;
        #1;
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_outst", 64'(outst_cnt_o), 64'd0);
        chk("rst_val", 64'(l15_req_val_o), 64'd0);
        chk("rst_ready", 64'(st_ready_o), 64'd1);
    endtask

    typedef struct {
        logic        sv;
        logic [63:0] a, d;
        logic [7:0]  be;
        logic        ack, sack;
        logic        e_ready, e_val;
        logic [63:0] e_addr, e_data;
        logic [7:0]  e_be;
        logic        e_empty;
        logic [3:0]  e_outst;
    } vec_t;
    vec_t tv[5];

    initial begin
        // Single store: issue, byte swap, completion
        tv[0] = '{1'b1, 64'h8000_0010, 64'h1122334455667788, 8'h0F, 1'b0, 1'b0,
                  1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 4'd0};
        tv[1] = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b0,
                  1'b1, 1'b1, 64'h8000_0010, 64'h8877665544332211, 8'hF0, 1'b0, 4'd0};
        tv[2] = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0,
                  1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 4'd1};
        tv[3] = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1,
                  1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 4'd1};
        tv[4] = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0,
                  1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 4'd0};

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            st_valid = tv[i].sv; st_addr = tv[i].a; st_data = tv[i].d; st_be = tv[i].be;
            st_nc = 1'b0; flush = 1'b0; req_ack = tv[i].ack; st_ack = tv[i].sack;
            @(negedge clk);
            chk("t1_ready", 64'(st_ready_o), 64'(tv[i].e_ready));
            chk("t1_val", 64'(l15_req_val_o), 64'(tv[i].e_val));
            chk("t1_empty", 64'(empty_o), 64'(tv[i].e_empty));
            chk("t1_outst", 64'(outst_cnt_o), 64'(tv[i].e_outst));
            if (tv[i].e_val) begin
                chk("t1_addr", l15_req_addr_o, tv[i].e_addr);
                chk("t1_data", l15_req_data_o, tv[i].e_data);
                chk("t1_be", 64'(l15_req_be_o), 64'(tv[i].e_be));
                chk("t1_nc", 64'(l15_req_nc_o), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        set_idle();

        // Merge into a tail that is not the presented head
        do_reset();
        cyc(1, 64'h40, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 0, 0);
        cyc(1, 64'h100, 64'h00000000000000AA, 8'h01, 0, 0, 0, 0);
        cyc(1, 64'h104, 64'hBB00000000000000, 8'h80, 0, 0, 0, 0);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 0);
        chk("t2_be", 64'(l15_req_be_o), MERGE ? 64'h81 : 64'h80);
        chk("t2_data", l15_req_data_o, MERGE ? 64'hAA000000000000BB : 64'hAA00000000000000);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 1);
        chk("t2_val_after", 64'(l15_req_val_o), MERGE ? 64'd0 : 64'd1);
        for (int i = 0; i < 8; i++) cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 1);
        chk("t2_empty", 64'(empty_o), 64'd1);

        // Fill to DEPTH, merge while full, free a slot
        do_reset();
        for (int i = 0; i < 8; i++)
            cyc(1, 64'h1000 + 64'(i * 8), 64'(i) * 64'h0101010101010101, 8'hFF, 0, 0, 0, 0);
        chk("t3_full_ready", 64'(st_ready_o), 64'd0);
        st_valid = 1'b1; st_addr = 64'h1038; st_be = 8'h02; st_nc = 1'b0;
        #1;
        chk("t3_merge_ready", 64'(st_ready_o), 64'(MERGE));
        cyc(1, 64'h1038, 64'h000000000000EE00, 8'h02, 0, 0, 0, 0);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 0);
        chk("t3_ready_after_pop", 64'(st_ready_o), 64'd1);
        for (int i = 0; i < 20; i++) cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 1);
        chk("t3_empty", 64'(empty_o), 64'd1);

        // Outstanding cap
        do_reset();
        for (int i = 0; i < 8; i++)
            cyc(1, 64'h2000 + 64'(i * 8), 64'(i + 1), 8'hFF, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            cyc(1, 64'h2100 + 64'(i * 8), 64'(i + 9), 8'hFF, 0, 0, 1, 0);
        chk("t4_cap_val", 64'(l15_req_val_o), 64'd0);
        chk("t4_cap_outst", 64'(outst_cnt_o), 64'd7);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 1);
        chk("t4_after_ack_outst", 64'(outst_cnt_o), 64'd6);
        chk("t4_after_ack_val", 64'(l15_req_val_o), 64'd1);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 1);
        chk("t4_issue_and_ack", 64'(outst_cnt_o), 64'd6);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 0);
        chk("t4_recap_outst", 64'(outst_cnt_o), 64'd7);
        chk("t4_recap_val", 64'(l15_req_val_o), 64'd0);
        for (int i = 0; i < 30; i++) cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 1);
        chk("t4_empty", 64'(empty_o), 64'd1);

        // Flush drain, then nc store never merges
        do_reset();
        for (int i = 0; i < 3; i++)
            cyc(1, 64'h3000 + 64'(i * 8), 64'(i + 3), 8'hFF, 0, 0, 0, 0);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 1, 0, 0);
        st_valid = 1'b1; st_addr = 64'h3100;
        #1;
        chk("t5_drain_ready", 64'(st_ready_o), 64'd0);
        st_valid = 1'b0;
        for (int i = 0; i < 12; i++) cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 1);
        chk("t5_empty", 64'(empty_o), 64'd1);
        chk("t5_ready_back", 64'(st_ready_o), 64'd1);
        cyc(1, 64'h3800, 64'h5, 8'hFF, 0, 0, 0, 0);
        cyc(1, 64'h4000, 64'h00000000CAFEF00D, 8'h0F, 0, 0, 0, 0);
        cyc(1, 64'h4000, 64'h1234567800000000, 8'hF0, 1, 0, 0, 0);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 0);
        chk("t5_first_nc", 64'(l15_req_nc_o), 64'd0);
        chk("t5_first_be", 64'(l15_req_be_o), 64'hF0);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 0);
        chk("t5_second_val", 64'(l15_req_val_o), 64'd1);
        chk("t5_second_nc", 64'(l15_req_nc_o), 64'd1);
        for (int i = 0; i < 8; i++) cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 1);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 6; i++)
            cyc(1, 64'h6000 + 64'(i * 8), 64'(i), 8'hFF, 0, 0, 0, 0);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 0);
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 1, 0);
        chk("t6_outst_before", 64'(outst_cnt_o), 64'd2);
        do_reset();
        cyc(0, 64'h0, 64'h0, 8'h00, 0, 0, 0, 1);
        chk("t6_stray_ack", 64'(outst_cnt_o), 64'd0);
        chk("t6_empty", 64'(empty_o), 64'd1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        sv, nc, fl, ack, sack;
            logic [63:0] a, d;
            logic [7:0]  be;
            sv   = ($urandom % 3) != 0;
            a    = 64'h5000 + 64'(($urandom % 4) * 8) + 64'($urandom % 8);
            d    = {$urandom, $urandom};
            be   = 8'($urandom);
            nc   = ($urandom % 8) == 0;
            fl   = ($urandom % 64) == 0;
            ack  = ($urandom % 2) == 0;
            sack = (m_outst > 0) ? (($urandom % 3) == 0) : (($urandom % 32) == 0);
            cyc(sv, a, d, be, nc, fl, ack, sack);
            if (($urandom % 700) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
